// File: rtl/vec_cat_pkg.sv
// Shared constants and types for the vector concatenation FIFO.
package vec_cat_pkg;

  localparam int DEF_BUS_WIDTH    = 96;
  localparam int DEF_VECTOR_WIDTH = 128;
  localparam int DEF_VEC_ID_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH   = 128;

  // Width of the high (second) word of a vector before zero-extension.
  function automatic int hi_bits(input int vector_width, input int bus_width);
    return vector_width - bus_width;
  endfunction

  localparam int HI_BITS = hi_bits(DEF_VECTOR_WIDTH, DEF_BUS_WIDTH);

  // Which half of the current vector the realigner emits next.
  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_e;

endpackage

// File: rtl/srl_fifo.sv
// First-word-fall-through FIFO built from a shift register plus an
// occupancy counter. New words enter at r_mem[0]; the head sits at
// r_mem[count-1].
module srl_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_Wr,
  input  logic [WIDTH-1:0] i_Data,
  input  logic             i_Rd,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Full,
  output logic             o_Empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_head_addr;

  assign o_Full      = (r_count == DEPTH_C);
  assign o_Empty     = (r_count == '0);
  // A write while full is dropped even if a pop frees a slot this cycle.
  assign w_push      = i_Wr && !o_Full;
  assign w_pop       = i_Rd && !o_Empty;
  assign w_head_addr = AW'(r_count - ONE_C);
  assign o_Data      = r_mem[w_head_addr];

  // Shift storage on every accepted write.
  // NOTE: the storage array has no reset; the occupancy counter alone
  // defines which entries are meaningful, so clearing data is wasted logic.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[0] <= i_Data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  // Occupancy counter; simultaneous push and pop leave it unchanged.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vec_cat_fifo.sv
// Buffers a packed, back-to-back vector stream and realigns it so each
// vector leaves as two bus words: the low BUS_WIDTH bits, then the
// remaining high bits zero-extended, both tagged with the vector ID.
module vec_cat_fifo
  import vec_cat_pkg::*;
#(
  parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int VEC_ID_WIDTH = DEF_VEC_ID_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_Wr,
  input  logic [BUS_WIDTH-1:0]    i_Data,
  output logic                    o_Full,
  output logic                    o_Empty,
  output logic [BUS_WIDTH-1:0]    o_Vector,
  output logic [VEC_ID_WIDTH-1:0] o_VecID,
  output logic                    o_Valid
);

  localparam int HI_W  = hi_bits(VECTOR_WIDTH, BUS_WIDTH);
  localparam int ACC_W = 2 * BUS_WIDTH;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0]        BUS_C = CNT_W'(BUS_WIDTH);
  localparam logic [CNT_W-1:0]        HI_C  = CNT_W'(HI_W);
  localparam logic [VEC_ID_WIDTH-1:0] ID_ONE = VEC_ID_WIDTH'(1);

  // Realigner state
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;
  phase_e                  r_ph;
  logic [VEC_ID_WIDTH-1:0] r_vec_id;

  // Registered outputs
  logic                    r_valid;
  logic [BUS_WIDTH-1:0]    r_vector;
  logic [VEC_ID_WIDTH-1:0] r_id_out;

  // Next-state signals
  logic [BUS_WIDTH-1:0]    w_head;
  logic                    w_pop;
  logic                    w_emit;
  logic [CNT_W-1:0]        w_emit_bits;
  logic [CNT_W-1:0]        w_cnt_after;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [ACC_W-1:0]        w_acc_next;
  phase_e                  w_ph_next;
  logic [VEC_ID_WIDTH-1:0] w_vec_id_next;
  logic [BUS_WIDTH-1:0]    w_vec_word;

  srl_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_Wr    (i_Wr),
    .i_Data  (i_Data),
    .i_Rd    (w_pop),
    .o_Data  (w_head),
    .o_Full  (o_Full),
    .o_Empty (o_Empty)
  );

  // Refill only when the accumulator has room for a whole word after this
  // cycle's emit; the decision uses the pre-pop bit count.
  assign w_pop = !o_Empty && (r_cnt <= BUS_C);

  // Emit decision, accumulator shift and merge of the popped head word.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_emit        = 1'b0;
    w_emit_bits   = '0;
    w_ph_next     = r_ph;
    w_vec_id_next = r_vec_id;
    w_vec_word    = '0;

    if (r_ph == PH_LO && r_cnt >= BUS_C) begin
      w_emit      = 1'b1;
      w_emit_bits = BUS_C;
      w_ph_next   = PH_HI;
      w_vec_word  = r_acc[BUS_WIDTH-1:0];
    end else if (r_ph == PH_HI && r_cnt >= HI_C) begin
      w_emit        = 1'b1;
      w_emit_bits   = HI_C;
      w_ph_next     = PH_LO;
      w_vec_id_next = r_vec_id + ID_ONE;
      w_vec_word    = BUS_WIDTH'(r_acc[HI_W-1:0]);
    end

    w_cnt_after = r_cnt - w_emit_bits;
    w_acc_next  = r_acc >> w_emit_bits;
    w_cnt_next  = w_cnt_after;

    if (w_pop) begin
      // Bits above the valid count are always zero, so OR merges cleanly.
      w_acc_next = w_acc_next | ({{BUS_WIDTH{1'b0}}, w_head} << w_cnt_after);
      w_cnt_next = w_cnt_after + BUS_C;
    end
  end

  // Realigner state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ph     <= PH_LO;
      r_vec_id <= '0;
    end else begin
      r_acc    <= w_acc_next;
      r_cnt    <= w_cnt_next;
      r_ph     <= w_ph_next;
      r_vec_id <= w_vec_id_next;
    end
  end

  // Output register: data and ID update only on an emit; valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_vector <= '0;
      r_id_out <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_vector <= w_vec_word;
        r_id_out <= r_vec_id;
      end
    end
  end

  assign o_Valid  = r_valid;
  assign o_Vector = r_vector;
  assign o_VecID  = r_id_out;

endmodule

// File: tb/tb_vec_cat_fifo.sv
// Directed bench for vec_cat_fifo with default parameters.
module tb_vec_cat_fifo;

  localparam int BW = 96;
  localparam int VW = 128;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_Wr = 1'b0;
  logic [BW-1:0] i_Data = '0;
  logic          o_Full;
  logic          o_Empty;
  logic [BW-1:0] o_Vector;
  logic [IW-1:0] o_VecID;
  logic          o_Valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [BW-1:0] q_vec [$];
  logic [IW-1:0] q_id  [$];

  vec_cat_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .i_Wr     (i_Wr),
    .i_Data   (i_Data),
    .o_Full   (o_Full),
    .o_Empty  (o_Empty),
    .o_Vector (o_Vector),
    .o_VecID  (o_VecID),
    .o_Valid  (o_Valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Capture every valid output word away from the active edge.
  always @(negedge clk) begin
    if (o_Valid) begin
      q_vec.push_back(o_Vector);
      q_id.push_back(o_VecID);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] make_vec(input int k);
    logic [31:0] kk;
    kk = k;
    return {kk ^ 32'hA5A5A5A5, ~kk, kk * 32'h9E3779B9, kk + 32'h01234567};
  endfunction

  // Word w of the LSB-first packed stream of vectors 0..nvec-1, zero padded.
  function automatic logic [BW-1:0] stream_word(input int w, input int nvec);
    logic [BW-1:0] r;
    logic [VW-1:0] v;
    int n, vi, prev;
    r = '0;
    v = '0;
    prev = -1;
    for (int b = 0; b < BW; b++) begin
      n  = w * BW + b;
      vi = n / VW;
      if (vi != prev) begin
        v    = (vi < nvec) ? make_vec(vi) : '0;
        prev = vi;
      end
      r[b] = v[n % VW];
    end
    return r;
  endfunction

  // Expected output word j: even = low half, odd = high bits zero-extended.
  function automatic logic [BW-1:0] exp_word(input int j, input int nvec);
    logic [VW-1:0] v;
    v = ((j / 2) < nvec) ? make_vec(j / 2) : '0;
    if (j % 2 == 0) return v[BW-1:0];
    return {{(2*BW-VW){1'b0}}, v[VW-1:BW]};
  endfunction

  function automatic int exp_out_count(input int words);
    int bits;
    bits = words * BW;
    return (bits / VW) * 2 + (((bits % VW) >= BW) ? 1 : 0);
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst  = 1'b1;
    i_Wr = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    q_vec.delete();
    q_id.delete();
  endtask

  // Keeps i_Wr high; a word refused because the FIFO was full is offered
  // again next cycle, so the accepted words form an unbroken stream.
  task automatic write_stream(input int max_cycles, input int max_words, input int nvec,
                              output int accepted, output bit full_seen);
    int  idx;
    int  c;
    bit  full_s;
    idx = 0;
    c = 0;
    full_seen = 1'b0;
    while (idx < max_words && c < max_cycles) begin
      full_s = o_Full;
      if (full_s) full_seen = 1'b1;
      i_Wr   = 1'b1;
      i_Data = stream_word(idx, nvec);
      @(negedge clk);
      c++;
      if (!full_s) idx++;
    end
    i_Wr = 1'b0;
    accepted = idx;
  endtask

  task automatic check_stream(input string tag, input int nwords, input int nvec);
    int n_exp;
    n_exp = exp_out_count(nwords);
    check($sformatf("%s count", tag), q_vec.size(), n_exp);
    for (int j = 0; j < n_exp && j < q_vec.size(); j++) begin
      check($sformatf("%s vec[%0d]", tag, j), q_vec[j], exp_word(j, nvec));
      check($sformatf("%s id[%0d]", tag, j), q_id[j], (j / 2) % 256);
    end
  endtask

  initial begin
    logic [VW-1:0]   v0, v1, v2;
    logic [3*VW-1:0] s3;
    logic [BW-1:0]   w0, w1;
    int              acc;
    bit              fs;

    // ---- Reset state
    do_reset(3);
    check("rst valid", o_Valid, 0);
    check("rst empty", o_Empty, 1);
    check("rst full",  o_Full,  0);
    check("rst vecid", o_VecID, 0);
    check("rst vector", o_Vector, 0);

    // ---- Single vector, cycle-exact latency
    w0 = {24{4'h1}};
    w1 = 96'h0000_0000_0000_0000_AAAA_AAAA;
    i_Wr = 1'b1;
    i_Data = w0;
    @(negedge clk);                 // W0 written at edge N
    i_Data = w1;
    check("t2 valid@N", o_Valid, 0);
    @(negedge clk);                 // N+1: W0 popped, W1 written
    i_Wr = 1'b0;
    check("t2 valid@N+1", o_Valid, 0);
    @(negedge clk);                 // N+2: low word emitted
    check("t2 lo valid", o_Valid, 1);
    check("t2 lo vec", o_Vector, w0);
    check("t2 lo id", o_VecID, 0);
    check("t2 empty", o_Empty, 1);
    @(negedge clk);                 // N+3: high word emitted
    check("t2 hi valid", o_Valid, 1);
    check("t2 hi vec", o_Vector, 96'hAAAA_AAAA);
    check("t2 hi id", o_VecID, 0);
    @(negedge clk);
    check("t2 idle valid", o_Valid, 0);

    // ---- Three vectors packed into four words
    do_reset(2);
    v0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    v1 = 128'hDEADBEEF_CAFEBABE_0BADF00D_12345678;
    v2 = 128'h55555555_AAAAAAAA_33333333_CCCCCCCC;
    s3 = {v2, v1, v0};
    for (int i = 0; i < 4; i++) begin
      i_Wr = 1'b1;
      i_Data = s3[i*BW +: BW];
      @(negedge clk);
    end
    i_Wr = 1'b0;
    repeat (20) @(negedge clk);
    check("t3 count", q_vec.size(), 6);
    if (q_vec.size() == 6) begin
      check("t3 v0 lo", q_vec[0], v0[95:0]);
      check("t3 v0 hi", q_vec[1], {64'h0, v0[127:96]});
      check("t3 v1 lo", q_vec[2], v1[95:0]);
      check("t3 v1 hi", q_vec[3], {64'h0, v1[127:96]});
      check("t3 v2 lo", q_vec[4], v2[95:0]);
      check("t3 v2 hi", q_vec[5], {64'h0, v2[127:96]});
      for (int j = 0; j < 6; j++) begin
        check($sformatf("t3 id[%0d]", j), q_id[j], j / 2);
      end
      check("t3 hi zero bits v1", q_vec[3][95:32], 0);
    end

    // ---- Continuous writes for 500 cycles: overflow and drop
    do_reset(2);
    write_stream(500, 1_000_000, 1_000_000, acc, fs);
    check("t4 full seen", fs, 1);
    check("t4 drops occurred", (acc < 500), 1);
    repeat (400) @(negedge clk);
    check("t4 drained empty", o_Empty, 1);
    check_stream("t4", acc, 1_000_000);

    // ---- 260 vectors: ID wraps 255 -> 0
    do_reset(2);
    write_stream(5000, 347, 260, acc, fs);
    check("t5 words accepted", acc, 347);
    repeat (400) @(negedge clk);
    check_stream("t5", 347, 260);
    if (q_id.size() >= 514) begin
      check("t5 id 255", q_id[511], 255);
      check("t5 id wrap", q_id[512], 0);
      check("t5 id wrap hi", q_id[513], 0);
    end

    // ---- Reset in the middle of a vector
    do_reset(2);
    write_stream(3, 3, 1_000_000, acc, fs);
    rst = 1'b1;
    @(negedge clk);
    check("t6 rst valid", o_Valid, 0);
    check("t6 rst vector", o_Vector, 0);
    check("t6 rst vecid", o_VecID, 0);
    check("t6 rst empty", o_Empty, 1);
    rst = 1'b0;
    q_vec.delete();
    q_id.delete();
    i_Wr = 1'b1;
    i_Data = v0[95:0];
    @(negedge clk);
    i_Data = {64'h0, v0[127:96]};
    @(negedge clk);
    i_Wr = 1'b0;
    repeat (10) @(negedge clk);
    check("t6 count", q_vec.size(), 2);
    if (q_vec.size() == 2) begin
      check("t6 lo vec", q_vec[0], v0[95:0]);
      check("t6 lo id", q_id[0], 0);
      check("t6 hi vec", q_vec[1], {64'h0, v0[127:96]});
      check("t6 hi id", q_id[1], 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vec_cat_fifo.md
VEC_CAT_FIFO -- requirements
Module: vec_cat_fifo

Interface
REQ-001 Parameter BUS_WIDTH, default 96, width of input and output bus words.
REQ-002 Parameter VECTOR_WIDTH, default 128, width of one fingerprint vector; legal range BUS_WIDTH < VECTOR_WIDTH <= 2*BUS_WIDTH.
REQ-003 Parameter VEC_ID_WIDTH, default 8, width of the vector ID counter.
REQ-004 Parameter FIFO_DEPTH, default 128, input FIFO depth in bus words.
REQ-005 Port clk, input, 1, the only clock; all logic on its rising edge.
REQ-006 Port rst, input, 1, reset: synchronous, active-high.
REQ-007 Port i_Wr, input, 1, write strobe for i_Data.
REQ-008 Port i_Data, input, BUS_WIDTH, packed vector stream word.
REQ-009 Port o_Full, output, 1, FIFO holds FIFO_DEPTH words.
REQ-010 Port o_Empty, output, 1, FIFO holds zero words.
REQ-011 Port o_Vector, output, BUS_WIDTH, realigned output word.
REQ-012 Port o_VecID, output, VEC_ID_WIDTH, ID of the vector o_Vector belongs to.
REQ-013 Port o_Valid, output, 1, o_Vector/o_VecID valid this cycle; no backpressure.

Function
REQ-014 Input stream: vectors packed back-to-back LSB-first; vector k occupies stream bits [k*VECTOR_WIDTH +: VECTOR_WIDTH]; stream bit n is bit n%BUS_WIDTH of word n/BUS_WIDTH.
REQ-015 FIFO: write accepted iff i_Wr && !o_Full; write while full is dropped, including when a pop occurs in the same cycle.
REQ-016 FIFO is first-word-fall-through: head word is presented to the realigner whenever !o_Empty; a pop while empty has no effect.
REQ-017 Realigner: accumulator ACC (2*BUS_WIDTH bits, LSB-aligned) and count CNT of valid bits; a phase bit PH (0 = low word, 1 = high word).
REQ-018 Pop: FIFO head is popped iff !o_Empty && CNT <= BUS_WIDTH; the popped word is merged into ACC at bit position (CNT minus bits emitted this cycle).
REQ-019 Emit low (PH=0, CNT >= BUS_WIDTH): o_Vector <= ACC[BUS_WIDTH-1:0]; ACC shifts right BUS_WIDTH; PH <= 1.
REQ-020 Emit high (PH=1, CNT >= VECTOR_WIDTH-BUS_WIDTH): o_Vector <= ACC[VECTOR_WIDTH-BUS_WIDTH-1:0] zero-extended to BUS_WIDTH; ACC shifts right VECTOR_WIDTH-BUS_WIDTH; PH <= 0.
REQ-021 Emit decisions use pre-pop CNT; at most one emit and one pop per cycle; CNT_next = CNT - emitted + (pop ? BUS_WIDTH : 0).
REQ-022 o_Valid is registered: high the cycle after an emit decision, else low.
REQ-023 o_VecID equals the vector counter for both words of a vector; counter increments after each high-word emit and wraps modulo 2^VEC_ID_WIDTH.
REQ-024 Each vector appears as exactly two consecutive o_Valid words, low then high.
REQ-025 Latency: a word written to an empty FIFO at edge N is popped at edge N+1; the first low word is valid after edge N+2.

Reset
REQ-026 While rst is high at a clock edge: FIFO count 0 (o_Empty=1, o_Full=0); CNT=0, ACC=0, PH=0, vector counter 0; o_Valid=0, o_Vector=0, o_VecID=0.
REQ-027 Reset mid-operation discards all buffered words and partial vectors; the first word written after reset starts vector 0 at bit 0.
REQ-028 FIFO storage contents are not reset.

Structure
REQ-029 Default parameter values and the derived constant HI_BITS = VECTOR_WIDTH-BUS_WIDTH live in a shared package vec_cat_pkg.
REQ-030 The FIFO is a separate sub-module srl_fifo (shift-register storage, occupancy counter, wr/rd/full/empty); the realigner lives in the top module.

Verification
REQ-031 Reset: rst high 3 cycles -> o_Valid=0, o_Empty=1, o_Full=0, o_VecID=0.
REQ-032 Single vector: write W0=96'h1..1, W1=96'h0..0_AAAAAAAA -> o_Vector 96'h1..1 (ID 0), then 96'h0..0_AAAAAAAA (ID 0); first valid 2 cycles after write edge.
REQ-033 Four words encoding vectors V0,V1,V2 -> exactly 6 valid words; IDs 0,0,1,1,2,2; high words have bits [95:32] zero.
REQ-034 Continuous writes every cycle for 500 cycles -> o_Full asserts, later writes are dropped, no output word is corrupted, and output order is preserved.
REQ-035 Stream 260 vectors -> o_VecID wraps 255 -> 0.
REQ-036 rst pulsed mid-vector -> outputs cleared next cycle; next vector emitted with ID 0 and correct alignment.
